// File: rtl/tx_fifo_pkg.sv
// rtl/tx_fifo_pkg.sv - shared UART parameters and transmit-queue FSM encoding
package tx_fifo_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_ADDR_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/tx_fifo_if.sv
// rtl/tx_fifo_if.sv - write and transmitter handshake bundle for tx_fifo
interface tx_fifo_if
  import tx_fifo_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
);

  logic [NB_DATA-1:0] i_wr_data;
  logic               i_wr_valid;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_full;
  logic               o_empty;
  logic [NB_ADDR:0]   o_count;
  logic               o_overflow;

  // Producer side: ALU interface stage writes, transmitter reports completion
  modport master (
    output i_wr_data, i_wr_valid, i_tx_done,
    input  o_tx_data, o_tx_start, o_full, o_empty, o_count, o_overflow
  );

  // FIFO side
  modport slave (
    input  i_wr_data, i_wr_valid, i_tx_done,
    output o_tx_data, o_tx_start, o_full, o_empty, o_count, o_overflow
  );

endinterface

// File: rtl/tx_fifo_mem.sv
// rtl/tx_fifo_mem.sv - dual-port register array, synchronous write, asynchronous read
module fifo_mem
  import tx_fifo_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic               i_clock,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_DATA-1:0] o_rdata
);

  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  // Contents are never reset; only the pointers decide what is valid
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - byte queue between the ALU interface stage and the UART transmitter
module tx_fifo
  import tx_fifo_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic     i_clock,
  input  logic     i_reset,
  tx_fifo_if.slave bus
);

  localparam int               DEPTH      = 2**NB_ADDR;
  localparam logic [NB_ADDR:0] FULL_COUNT = (NB_ADDR+1)'(DEPTH);

  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR-1:0] rd_ptr;
  logic [NB_ADDR:0]   count;
  logic               overflow;
  logic [NB_DATA-1:0] rd_data;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;
  tx_state_t          state;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Flags come only from the registered count, so a pop on the same edge
  // cannot make room for a write that arrives while full.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign push  = bus.i_wr_valid && !full;
  assign pop   = (state == ST_IDLE) && !empty;

  fifo_mem #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_mem (
    .i_clock (i_clock),
    .i_we    (push),
    .i_waddr (wr_ptr),
    .i_wdata (bus.i_wr_data),
    .i_raddr (rd_ptr),
    .o_rdata (rd_data)
  );

  // Pointer, occupancy and sticky overflow bookkeeping
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + NB_ADDR'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + NB_ADDR'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (NB_ADDR+1)'(1);
        2'b01:   count <= count - (NB_ADDR+1)'(1);
        default: count <= count;
      endcase
      if (bus.i_wr_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Transmit sequencer: latch head byte, pulse start once, wait for done
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_start <= 1'b0;
          if (!empty) begin
            tx_data <= rd_data;
            state   <= ST_START;
          end
        end
        ST_START: begin
          tx_start <= 1'b1;
          state    <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          tx_start <= 1'b0;
          if (bus.i_tx_done) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_tx_data   = tx_data;
  assign bus.o_tx_start  = tx_start;
  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_count     = count;
  assign bus.o_overflow  = overflow;

endmodule

// File: tb/tb_tx_fifo.sv
// tb/tb_tx_fifo.sv - directed self-checking bench for tx_fifo with a byte scoreboard
module tb_tx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         starts     = 0;
  logic [4:0] max_count  = '0;
  bit         auto_en    = 1'b1;
  bit         stall      = 1'b0;
  int         done_delay = 10;

  tx_fifo_if #(.NB_DATA(8), .NB_ADDR(4)) bus ();

  tx_fifo #(
    .NB_DATA (8),
    .NB_ADDR (4)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic write_byte(input logic [7:0] d, input bit accept);
    bus.i_wr_data  = d;
    bus.i_wr_valid = 1'b1;
    if (accept) exp_q.push_back(d);
    @(negedge clk);
    bus.i_wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (done_delay + 6) @(negedge clk);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_empty"}, bus.o_empty, 1'b1);
  endtask

  // Scoreboard monitor: every start pulse must carry the oldest expected byte
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_count > max_count) max_count = bus.o_count;
      if (bus.o_tx_start === 1'b1) begin
        starts++;
        if (exp_q.size() == 0) check("unexpected_start", 1, 0);
        else check("tx_data", bus.o_tx_data, exp_q.pop_front());
      end
    end
  end

  // Transmitter model: answers each start with a done pulse after done_delay
  initial begin
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_tx_start === 1'b1 && auto_en) begin
        for (int i = 1; i < done_delay; i++) @(negedge clk);
        while (stall) @(negedge clk);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    bus.i_wr_data  = '0;
    bus.i_wr_valid = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_empty", bus.o_empty, 1'b1);
    check("rst_full", bus.o_full, 1'b0);
    check("rst_count", bus.o_count, 0);
    check("rst_overflow", bus.o_overflow, 1'b0);
    check("rst_tx_start", bus.o_tx_start, 1'b0);
    check("rst_tx_data", bus.o_tx_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Single byte: start visible in the cycle after write edge + 2
    write_byte(8'hA5, 1'b1);
    check("single_start_n0", bus.o_tx_start, 1'b0);
    check("single_count_n0", bus.o_count, 1);
    check("single_empty_n0", bus.o_empty, 1'b0);
    @(negedge clk);
    check("single_start_n1", bus.o_tx_start, 1'b0);
    check("single_empty_after_pop", bus.o_empty, 1'b1);
    @(negedge clk);
    check("single_start_n2", bus.o_tx_start, 1'b1);
    check("single_data_n2", bus.o_tx_data, 8'hA5);
    wait_drain("single");

    // Burst of five with a slow transmitter
    s0 = starts;
    max_count = '0;
    for (int i = 1; i <= 5; i++) write_byte(8'(i), 1'b1);
    wait_drain("burst");
    check("burst_starts", starts - s0, 5);
    check("burst_peak_count", max_count, 5'd4);

    // Overflow: transmitter stalled, 18 writes, last one dropped
    stall = 1'b1;
    for (int i = 0; i < 18; i++) write_byte(8'(8'h10 + i), (i < 17));
    check("ovf_count", bus.o_count, 16);
    check("ovf_full", bus.o_full, 1'b1);
    check("ovf_flag", bus.o_overflow, 1'b1);
    check("ovf_in_flight_data", bus.o_tx_data, 8'h10);
    stall = 1'b0;
    wait_drain("ovf");
    check("ovf_sticky", bus.o_overflow, 1'b1);
    check("ovf_full_cleared", bus.o_full, 1'b0);

    // Wrap: three rounds of 12 writes and drains
    done_delay = 2;
    s0 = starts;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) write_byte(8'(8'h80 + r * 12 + i), 1'b1);
      wait_drain("wrap");
    end
    check("wrap_starts", starts - s0, 36);

    // Simultaneous write and IDLE pop at count 3
    auto_en = 1'b0;
    for (int i = 0; i < 4; i++) write_byte(8'(8'h40 + i), 1'b1);
    check("simul_count_before", bus.o_count, 3);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    write_byte(8'h44, 1'b1);
    check("simul_count_after", bus.o_count, 3);
    auto_en = 1'b1;
    done_delay = 3;
    wait_drain("simul");

    // Mid-reset during WAIT_DONE with count 5; stray done later must be ignored
    done_delay = 20;
    for (int i = 0; i < 6; i++) write_byte(8'(8'h60 + i), 1'b1);
    check("midrst_count_before", bus.o_count, 5);
    rst = 1'b1;
    exp_q.delete();
    s0 = starts;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_count", bus.o_count, 0);
    check("midrst_empty", bus.o_empty, 1'b1);
    check("midrst_tx_start", bus.o_tx_start, 1'b0);
    check("midrst_overflow", bus.o_overflow, 1'b0);
    repeat (40) @(negedge clk);
    check("midrst_no_start", starts - s0, 0);
    check("midrst_still_empty", bus.o_empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_fifo.md
TX_FIFO -- requirements
Module: tx_fifo

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, byte width.
REQ-002 SHALL have parameter NB_ADDR, default 4, address width; depth = 2^NB_ADDR (16 entries).
REQ-003 SHALL have port i_clock, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_wr_data, input, NB_DATA, result byte from ALU interface stage.
REQ-006 SHALL have port i_wr_valid, input, 1, one-cycle write strobe (interface done pulse).
REQ-007 SHALL have port i_tx_done, input, 1, one-cycle pulse from transmitter after stop bit.
REQ-008 SHALL have port o_tx_data, output, NB_DATA, byte presented to transmitter.
REQ-009 SHALL have port o_tx_start, output, 1, one-cycle start pulse to transmitter.
REQ-010 SHALL have port o_full, output, 1, count == 2^NB_ADDR.
REQ-011 SHALL have port o_empty, output, 1, count == 0.
REQ-012 SHALL have port o_count, output, NB_ADDR+1, bytes stored (excluding byte in flight).
REQ-013 SHALL have port o_overflow, output, 1, sticky flag for dropped write.

Function
REQ-014 SHALL store i_wr_data at write pointer on any edge where i_wr_valid=1 and o_full=0, then increment write pointer modulo 2^NB_ADDR.
REQ-015 SHALL drop a write when o_full=1, even if a pop occurs on the same edge, and set o_overflow=1 until reset.
REQ-016 SHALL implement FSM states IDLE, START, WAIT_DONE.
REQ-017 IDLE: if o_empty=0, SHALL register head entry into o_tx_data, increment read pointer modulo 2^NB_ADDR, and go to START; else SHALL remain in IDLE.
REQ-018 START: SHALL hold o_tx_start=1 for exactly this one cycle, then go to WAIT_DONE unconditionally.
REQ-019 WAIT_DONE: SHALL stay until i_tx_done=1, then go to IDLE.
REQ-020 SHALL ignore i_tx_done in IDLE and START.
REQ-021 SHALL hold o_tx_data stable from START through the cycle i_tx_done is sampled.
REQ-022 o_count SHALL be +1 on accepted write only, -1 on pop only, unchanged on simultaneous accepted write and pop.
REQ-023 Latency: byte written into empty FIFO at edge N SHALL produce o_tx_start high in the cycle following edge N+2.
REQ-024 Back-to-back bytes SHALL be separated by at least one IDLE cycle after i_tx_done (next o_tx_start no earlier than 2 cycles after done).
REQ-025 o_full, o_empty, o_count SHALL be derived from registered state, with no combinational path from i_wr_valid or i_tx_done.

Reset
REQ-026 On i_reset=1 at a clock edge, SHALL clear both pointers, count, and o_overflow; set FSM to IDLE; and drive o_tx_start=0, o_tx_data=0, o_empty=1, o_full=0.
REQ-027 Reset SHALL take priority over every write and pop in the same cycle; a byte in flight is abandoned; storage contents need not be cleared.

Structure
REQ-028 SHALL import NB_DATA, NB_ADDR defaults and FSM state encoding from a shared UART package.
REQ-029 SHALL instantiate one sub-module, fifo_mem: a simple dual-port register array with synchronous write and asynchronous read.
REQ-030 SHALL sit between the ALU interface stage and the transmitter in the top-level, replacing their direct connection.

Verification
REQ-031 Single byte: write 0xA5 at cycle 0 -> o_tx_start pulse at cycle 3 with o_tx_data=0xA5; o_empty=1 after pop.
REQ-032 Burst: write 0x01..0x05 on consecutive cycles, i_tx_done 10 cycles after each start -> five starts, data 0x01..0x05 in order, o_count peaks at 4.
REQ-033 Overflow: stall i_tx_done, write 18 bytes 0x10..0x21 -> 1 in flight, o_count=16, o_full=1, o_overflow=1, 0x21 dropped; drained output 0x10..0x20.
REQ-034 Wrap: three rounds of 12 writes/12 drains -> all 36 bytes emitted in order, pointers wrap with no loss.
REQ-035 Simultaneous: write on the same edge as the IDLE pop with count=3 -> o_count stays 3.
REQ-036 Mid-reset: assert i_reset during WAIT_DONE with count=5 -> next cycle o_count=0, o_empty=1, o_tx_start=0, o_overflow=0; later stray i_tx_done ignored.
